cmplx_mult_pipe: RTL and testbench

//  Pipelined, parametrised complex (twiddle) multiplier for the FFT butterfly datapath: out = in * W, or in * conj(W) for inverse FFT.

---
 rtl/cmplx_mult_pipe.sv | 133 +++++++++++++
 tb/tb_cmplx_mult_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmplx_mult_pipe.sv
// Pipelined complex twiddle multiplier: out = in * W (or in * conj(W)).
// Three stages (capture, multiply, sum/round/narrow) on one global enable, so a stall freezes the whole pipe.
module cmplx_mult_pipe #(
    parameter int IN_W     = 16,
    parameter int W_W      = 16,
    parameter int OUT_W    = 16,
    parameter int FRAC_W   = 8,
    parameter int ROUND_EN = 1,
    parameter int SAT_EN   = 1,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_r,
    input  logic [IN_W-1:0]  in_i,
    input  logic [W_W-1:0]   w_r,
    input  logic [W_W-1:0]   w_i,
    input  logic             conj,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_r,
    output logic [OUT_W-1:0] out_i,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf,
    output logic             ovf_sticky
);
    localparam int P_W = IN_W + W_W;
    localparam int S   = P_W + 1;
    localparam int RSH = (FRAC_W > 0) ? FRAC_W - 1 : 0;
    localparam logic signed [S-1:0] RND =
        (ROUND_EN != 0 && FRAC_W > 0) ? ({{(S-1){1'b0}}, 1'b1} << RSH) : '0;
    localparam logic signed [S-1:0] OMAX = {{(S-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [S-1:0] OMIN = {{(S-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Returns {overflow, narrowed value}.
    function automatic logic [OUT_W:0] narrow(input logic signed [S-1:0] v);
        logic fits;
        fits = (v <= OMAX) && (v >= OMIN);
        if (SAT_EN != 0 && v > OMAX) return {1'b1, OMAX[OUT_W-1:0]};
        if (SAT_EN != 0 && v < OMIN) return {1'b1, OMIN[OUT_W-1:0]};
        return {!fits, v[OUT_W-1:0]};
    endfunction

    logic                    en;
    logic [3:1]              vld_pipe_q;
    logic signed [IN_W-1:0]  ar_q, ai_q;
    logic signed [W_W-1:0]   wr_q, wi_q;
    logic                    cj1_q, cj2_q;
    logic [TAG_W-1:0]        tag1_q, tag2_q, tag3_q;
    logic signed [P_W-1:0]   prr_q, pii_q, pri_q, pir_q;
    logic signed [P_W-1:0]   prr_d, pii_d, pri_d, pir_d;
    logic signed [P_W-1:0]   ar_x, ai_x, wr_x, wi_x;
    logic signed [S-1:0]     e_rr, e_ii, e_ri, e_ir, re_s, im_s, re_d, im_d;
    logic [OUT_W:0]          nr_d, ni_d;
    logic [OUT_W-1:0]        or_q, oi_q;
    logic                    ovf_q, sticky_q;

    assign en       = !vld_pipe_q[3] || out_ready;
    assign in_ready = en;

    always_comb begin
        ar_x  = {{W_W{ar_q[IN_W-1]}}, ar_q};
        ai_x  = {{W_W{ai_q[IN_W-1]}}, ai_q};
        wr_x  = {{IN_W{wr_q[W_W-1]}}, wr_q};
        wi_x  = {{IN_W{wi_q[W_W-1]}}, wi_q};
        prr_d = ar_x * wr_x;
        pii_d = ai_x * wi_x;
        pri_d = ar_x * wi_x;
        pir_d = ai_x * wr_x;
    end

    // Conjugation is folded into the add/sub signs so -2^(W_W-1) is never negated.
    always_comb begin
        e_rr = {prr_q[P_W-1], prr_q};
        e_ii = {pii_q[P_W-1], pii_q};
        e_ri = {pri_q[P_W-1], pri_q};
        e_ir = {pir_q[P_W-1], pir_q};
        if (cj2_q) begin
            re_s = e_rr + e_ii;
            im_s = e_ir - e_ri;
        end else begin
            re_s = e_rr - e_ii;
            im_s = e_ri + e_ir;
        end
        re_d = (re_s + RND) >>> FRAC_W;
        im_d = (im_s + RND) >>> FRAC_W;
        nr_d = narrow(re_d);
        ni_d = narrow(im_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            ar_q <= '0; ai_q <= '0; wr_q <= '0; wi_q <= '0;
            cj1_q <= 1'b0; cj2_q <= 1'b0;
            tag1_q <= '0; tag2_q <= '0; tag3_q <= '0;
            prr_q <= '0; pii_q <= '0; pri_q <= '0; pir_q <= '0;
            or_q <= '0; oi_q <= '0; ovf_q <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            if (en) begin
                vld_pipe_q <= {vld_pipe_q[2:1], in_valid};
                ar_q   <= in_r;
                ai_q   <= in_i;
                wr_q   <= w_r;
                wi_q   <= w_i;
                cj1_q  <= conj;
                tag1_q <= in_tag;
                prr_q  <= prr_d;
                pii_q  <= pii_d;
                pri_q  <= pri_d;
                pir_q  <= pir_d;
                cj2_q  <= cj1_q;
                tag2_q <= tag1_q;
                or_q   <= nr_d[OUT_W-1:0];
                oi_q   <= ni_d[OUT_W-1:0];
                ovf_q  <= nr_d[OUT_W] | ni_d[OUT_W];
                tag3_q <= tag2_q;
            end
            if (vld_pipe_q[3] && out_ready && ovf_q) sticky_q <= 1'b1;
        end
    end

    assign out_valid  = vld_pipe_q[3];
    assign out_r      = or_q;
    assign out_i      = oi_q;
    assign out_tag    = tag3_q;
    assign out_ovf    = ovf_q;
    assign ovf_sticky = sticky_q;
endmodule

// File: tb/tb_cmplx_mult_pipe.sv
// Self-checking bench for cmplx_mult_pipe: directed cases plus randomized traffic with backpressure,
// all compared against a plain-arithmetic reference model.
module tb_cmplx_mult_pipe;
    localparam int IN_W = 16, W_W = 16, OUT_W = 16, FRAC_W = 8, ROUND_EN = 1, SAT_EN = 1, TAG_W = 4;

    logic             clk, rst_n;
    logic             in_valid, in_ready, conj, out_valid, out_ready, out_ovf, ovf_sticky;
    logic [IN_W-1:0]  in_r, in_i;
    logic [W_W-1:0]   w_r, w_i;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [OUT_W-1:0] out_r, out_i;
    bit               bp_en;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        longint           r;
        longint           i;
        logic [TAG_W-1:0] tag;
        bit               ov;
    } exp_t;
    exp_t q[$];
    bit   msticky;

    cmplx_mult_pipe #(.IN_W(IN_W), .W_W(W_W), .OUT_W(OUT_W), .FRAC_W(FRAC_W),
                      .ROUND_EN(ROUND_EN), .SAT_EN(SAT_EN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_i(in_i), .w_r(w_r), .w_i(w_i), .conj(conj), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
        .out_tag(out_tag), .out_ovf(out_ovf), .ovf_sticky(ovf_sticky)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference arithmetic: exact integer product, floor division, then clamp.
    function automatic longint fdiv(input longint x, input longint d);
        longint qt;
        qt = x / d;
        if ((x % d != 0) && (x < 0)) qt -= 1;
        return qt;
    endfunction

    function automatic longint scale_sat(input longint x, output bit ov);
        longint v, hi, lo;
        v  = fdiv(x + (ROUND_EN != 0 ? (longint'(1) << (FRAC_W - 1)) : 0), longint'(1) << FRAC_W);
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        ov = (v > hi) || (v < lo);
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v;
    endfunction

    task automatic model(input longint ar, input longint ai, input longint wr, input longint wi,
                         input bit cj, output longint er, output longint ei, output bit ov);
        longint re, im;
        bit     o1, o2;
        re = cj ? (ar * wr + ai * wi) : (ar * wr - ai * wi);
        im = cj ? (ai * wr - ar * wi) : (ar * wi + ai * wr);
        er = scale_sat(re, o1);
        ei = scale_sat(im, o2);
        ov = o1 | o2;
    endtask

    // Backpressure driver.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: samples on the falling edge, away from the active edge.
    logic [OUT_W-1:0] p_r, p_i;
    logic [TAG_W-1:0] p_tag;
    logic             p_ovf, p_stall;
    initial begin
        exp_t   e;
        longint er, ei;
        bit     eo;
        p_stall = 1'b0;
        msticky = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                msticky = 1'b0;
                p_stall = 1'b0;
                check("rst_out_valid", out_valid, 0);
            end else begin
                check("in_ready", in_ready, !(out_valid && !out_ready));
                check("ovf_sticky", ovf_sticky, msticky);
                if (p_stall) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_r", out_r, p_r);
                    check("stall_i", out_i, p_i);
                    check("stall_tag", out_tag, p_tag);
                    check("stall_ovf", out_ovf, p_ovf);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL spurious_out: out_valid with tag %0d, expected no output", out_tag);
                    end else begin
                        e = q.pop_front();
                        check("out_r", longint'($signed(out_r)), e.r);
                        check("out_i", longint'($signed(out_i)), e.i);
                        check("out_tag", out_tag, e.tag);
                        check("out_ovf", out_ovf, e.ov);
                        if (e.ov) msticky = 1'b1;
                    end
                end
                if (in_valid && in_ready) begin
                    model($signed(in_r), $signed(in_i), $signed(w_r), $signed(w_i), conj, er, ei, eo);
                    e.r = er; e.i = ei; e.tag = in_tag; e.ov = eo;
                    q.push_back(e);
                end
                p_stall = out_valid && !out_ready;
                p_r = out_r; p_i = out_i; p_tag = out_tag; p_ovf = out_ovf;
            end
        end
    end

    // One sample into an idle pipe with no backpressure; checks latency and literal results.
    task automatic directed(input string nm, input int ar, input int ai, input int wr, input int wi,
                            input bit cj, input int tag, input int er, input int ei, input bit eov,
                            input bit est);
        int n;
        in_r = 16'(ar); in_i = 16'(ai); w_r = 16'(wr); w_i = 16'(wi);
        conj = cj; in_tag = 4'(tag); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_latency"}, n, 3);
        check({nm, "_r"}, longint'($signed(out_r)), er);
        check({nm, "_i"}, longint'($signed(out_i)), ei);
        check({nm, "_tag"}, out_tag, tag);
        check({nm, "_ovf"}, out_ovf, eov);
        @(posedge clk); #1;
        check({nm, "_sticky"}, ovf_sticky, est);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && q.size() != 0; k++) @(posedge clk);
        check("drain_queue_empty", q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rnd_val();
        case ($urandom_range(0, 3))
            0: return 16'($urandom);
            1: return 16'($urandom_range(0, 600) - 300);
            2: return $urandom_range(0, 1) ? 16'h7fff : 16'h8000;
            default: return 16'($urandom_range(0, 512) - 256);
        endcase
    endfunction

    initial begin
        longint mr, mi;
        bit     mo;
        bp_en = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; conj = 1'b0;
        in_r = '0; in_i = '0; w_r = '0; w_i = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_r", out_r, 0);
        check("reset_out_i", out_i, 0);
        check("reset_out_tag", out_tag, 0);
        check("reset_out_ovf", out_ovf, 0);
        check("reset_sticky", ovf_sticky, 0);
        check("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // Pin the reference model with hand-computed results.
        model(100, -50, 256, 0, 0, mr, mi, mo);
        check("model_ident_r", mr, 100); check("model_ident_i", mi, -50); check("model_ident_ov", mo, 0);
        model(100, -50, 0, 256, 1, mr, mi, mo);
        check("model_conj_r", mr, -50); check("model_conj_i", mi, -100);
        model(-3, 0, 128, 0, 0, mr, mi, mo);
        check("model_round_neg", mr, -1);
        model(32767, 32767, 256, 256, 0, mr, mi, mo);
        check("model_sat_i", mi, 32767); check("model_sat_ov", mo, 1);

        repeat (2) @(posedge clk);
        #1;
        directed("ident", 100, -50, 256, 0, 0, 3, 100, -50, 0, 0);
        directed("rot", 100, -50, 0, 256, 0, 4, 50, 100, 0, 0);
        directed("rotconj", 100, -50, 0, 256, 1, 5, -50, -100, 0, 0);
        directed("round_pos", 3, 0, 128, 0, 0, 6, 2, 0, 0, 0);
        directed("round_neg", -3, 0, 128, 0, 0, 7, -1, 0, 0, 0);
        directed("sat", 32767, 32767, 256, 256, 0, 8, 0, 32767, 1, 1);
        directed("clean_after_sat", 100, -50, 256, 0, 0, 9, 100, -50, 0, 1);
        directed("wmin_conj", 1000, 2000, -32768, -32768, 1, 1, -32768, -32768, 1, 1);

        // Randomized traffic with random bubbles and backpressure.
        bp_en = 1'b1;
        for (int k = 0; k < 400; k++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_r = rnd_val(); in_i = rnd_val(); w_r = rnd_val(); w_i = rnd_val();
            conj = 1'($urandom_range(0, 1));
            in_tag = 4'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        bp_en = 1'b0;
        drain();

        // Reset with three samples in flight.
        for (int k = 0; k < 3; k++) begin
            in_r = 16'(200 + k); in_i = 16'(k); w_r = 16'd256; w_i = '0; conj = 1'b0;
            in_tag = 4'(10 + k); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_r", out_r, 0);
        check("midrst_out_i", out_i, 0);
        check("midrst_out_tag", out_tag, 0);
        check("midrst_out_ovf", out_ovf, 0);
        check("midrst_sticky", ovf_sticky, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("postrst_no_stale", out_valid, 0);
        end
        directed("post_reset", -700, 300, 256, 0, 0, 2, -700, 300, 0, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
